// File: rtl/instr_tick_pkg.sv
// rtl/instr_tick_pkg.sv - shared constants and helpers for the instrument tick generator
// Purpose: default counter width, reset period, system clock rate and the
//          frequency-to-period conversion used when programming channels.
// Ports:   none (package).
package instr_tick_pkg;

   localparam int          DEF_CNT_W  = 25;
   localparam int unsigned DEF_PERIOD = 1250000;
   localparam int unsigned CLK_HZ     = 50000000;

   // Period in CLOCK_50 cycles for a tick rate of hz; hz = 0 yields period 0,
   // which parks the channel rather than dividing by zero.
   function automatic logic [DEF_CNT_W-1:0] period_for_hz(input int unsigned hz);
      int unsigned div;
      div = (hz == 32'd0) ? 32'd0 : CLK_HZ / hz;
      return div[DEF_CNT_W-1:0];
   endfunction

endpackage

// File: rtl/tick_channel.sv
// rtl/tick_channel.sv - one programmable tick/square-wave divider channel
// Purpose: period register, cycle counter, one-cycle tick and 50% square wave.
// Ports:
//   clk     in   system clock, rising edge
//   resetn  in   asynchronous active-low reset
//   en      in   run enable; low pauses the channel without losing phase
//   sync    in   restart phase: counter, tick and square wave cleared
//   ld      in   load ld_val as the new period and restart the counter
//   ld_val  in   period to load, in clock cycles
//   tick    out  one-cycle pulse per elapsed period
//   sq      out  square wave toggling on each tick
module tick_channel
   import instr_tick_pkg::*;
#(
   parameter int          CNT_W          = DEF_CNT_W,
   parameter int unsigned DEFAULT_PERIOD = DEF_PERIOD
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             en,
   input  logic             sync,
   input  logic             ld,
   input  logic [CNT_W-1:0] ld_val,
   output logic             tick,
   output logic             sq
);

   localparam logic [CNT_W-1:0] PER_RST = CNT_W'(DEFAULT_PERIOD);
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

   logic [CNT_W-1:0] per_q, per_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tick_q, tick_d;
   logic             sq_q, sq_d;

   always_comb begin
      per_d  = per_q;
      cnt_d  = cnt_q;
      tick_d = 1'b0;
      sq_d   = sq_q;

      // The period register takes a write even while sync is active.
      if (ld) begin
         per_d = ld_val;
      end

      if (sync) begin
         cnt_d = '0;
         sq_d  = 1'b0;
      end else if (ld) begin
         // A load beats a coincident terminal count; that tick is dropped.
         cnt_d = '0;
      end else if (en && (per_q != '0)) begin
         // per_q is non-zero here, so per_q - 1 never wraps.
         if (cnt_q == (per_q - ONE)) begin
            cnt_d  = '0;
            tick_d = 1'b1;
            sq_d   = ~sq_q;
         end else begin
            cnt_d = cnt_q + ONE;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         per_q  <= PER_RST;
         cnt_q  <= '0;
         tick_q <= 1'b0;
         sq_q   <= 1'b0;
      end else begin
         per_q  <= per_d;
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
         sq_q   <= sq_d;
      end
   end

   assign tick = tick_q;
   assign sq   = sq_q;

endmodule

// File: rtl/instr_tick_gen.sv
// rtl/instr_tick_gen.sv - multi-channel programmable tick generator for instrument voices
// Purpose: NUM_CH independent dividers of CLOCK_50 with runtime-writable periods,
//          a write acknowledge and a global phase sync.
// Ports:
//   CLOCK_50   in   system clock, rising edge
//   resetn     in   asynchronous active-low reset
//   en         in   per-channel run enable
//   sync       in   phase restart of all channels
//   wr_en      in   single-cycle period write strobe
//   wr_ch      in   channel to write; values >= NUM_CH are ignored
//   wr_period  in   new period in cycles
//   wr_ack     out  one-cycle pulse the cycle after an accepted write
//   tick       out  per-channel one-cycle tick
//   sq         out  per-channel square wave
module instr_tick_gen
   import instr_tick_pkg::*;
#(
   parameter int          NUM_CH         = 4,
   parameter int          CNT_W          = DEF_CNT_W,
   parameter int unsigned DEFAULT_PERIOD = DEF_PERIOD,
   parameter int          CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              CLOCK_50,
   input  logic              resetn,
   input  logic [NUM_CH-1:0] en,
   input  logic              sync,
   input  logic              wr_en,
   input  logic [CH_W-1:0]   wr_ch,
   input  logic [CNT_W-1:0]  wr_period,
   output logic              wr_ack,
   output logic [NUM_CH-1:0] tick,
   output logic [NUM_CH-1:0] sq
);

   logic [NUM_CH-1:0] ld;
   logic              wr_ack_q, wr_ack_d;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      // One-hot decode: an out-of-range wr_ch matches no channel.
      assign ld[i] = wr_en && (wr_ch == CH_W'(i));

      tick_channel #(
         .CNT_W          (CNT_W),
         .DEFAULT_PERIOD (DEFAULT_PERIOD)
      ) u_ch (
         .clk    (CLOCK_50),
         .resetn (resetn),
         .en     (en[i]),
         .sync   (sync),
         .ld     (ld[i]),
         .ld_val (wr_period),
         .tick   (tick[i]),
         .sq     (sq[i])
      );
   end

   // Acknowledge only writes that landed on a real channel.
   assign wr_ack_d = |ld;

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         wr_ack_q <= 1'b0;
      end else begin
         wr_ack_q <= wr_ack_d;
      end
   end

   assign wr_ack = wr_ack_q;

endmodule

// File: tb/tb_instr_tick_gen.sv
// tb/tb_instr_tick_gen.sv - directed self-checking bench for instr_tick_gen
module tb_instr_tick_gen;
   import instr_tick_pkg::*;

   localparam logic [24:0] DEF = 25'd1250000;

   logic        CLOCK_50 = 1'b0;
   logic        resetn;
   logic [3:0]  en;
   logic        sync;
   logic        wr_en;
   logic [1:0]  wr_ch;
   logic [24:0] wr_period;
   logic        wr_ack;
   logic [3:0]  tick;
   logic [3:0]  sq;
   logic        wr_ack3;
   logic [2:0]  tick3;
   logic [2:0]  sq3;

   int n_checks = 0;
   int n_fail   = 0;

   always #10 CLOCK_50 = ~CLOCK_50;

   instr_tick_gen #(.NUM_CH(4)) dut (
      .CLOCK_50  (CLOCK_50),
      .resetn    (resetn),
      .en        (en),
      .sync      (sync),
      .wr_en     (wr_en),
      .wr_ch     (wr_ch),
      .wr_period (wr_period),
      .wr_ack    (wr_ack),
      .tick      (tick),
      .sq        (sq)
   );

   // Three-channel instance so that wr_ch = NUM_CH is representable.
   instr_tick_gen #(.NUM_CH(3)) dut3 (
      .CLOCK_50  (CLOCK_50),
      .resetn    (resetn),
      .en        (en[2:0]),
      .sync      (sync),
      .wr_en     (wr_en),
      .wr_ch     (wr_ch),
      .wr_period (wr_period),
      .wr_ack    (wr_ack3),
      .tick      (tick3),
      .sq        (sq3)
   );

   function automatic logic [24:0] main_per(input int i);
      case (i)
         0:       return dut.g_ch[0].u_ch.per_q;
         1:       return dut.g_ch[1].u_ch.per_q;
         2:       return dut.g_ch[2].u_ch.per_q;
         default: return dut.g_ch[3].u_ch.per_q;
      endcase
   endfunction

   function automatic logic [24:0] main_cnt(input int i);
      case (i)
         0:       return dut.g_ch[0].u_ch.cnt_q;
         1:       return dut.g_ch[1].u_ch.cnt_q;
         2:       return dut.g_ch[2].u_ch.cnt_q;
         default: return dut.g_ch[3].u_ch.cnt_q;
      endcase
   endfunction

   function automatic logic [24:0] d3_per(input int i);
      case (i)
         0:       return dut3.g_ch[0].u_ch.per_q;
         1:       return dut3.g_ch[1].u_ch.per_q;
         default: return dut3.g_ch[2].u_ch.per_q;
      endcase
   endfunction

   task automatic cyc();
      @(posedge CLOCK_50);
      #1;
   endtask

   task automatic do_reset();
      resetn    = 1'b0;
      en        = 4'b0;
      sync      = 1'b0;
      wr_en     = 1'b0;
      wr_ch     = 2'd0;
      wr_period = 25'd0;
      cyc();
      cyc();
      resetn = 1'b1;
   endtask

   task automatic test_reset();
      logic [24:0] p;
      do_reset();
      n_checks++; if (tick !== 4'b0) begin n_fail++; $display("FAIL reset_tick: got %b expected 0000", tick); end
      n_checks++; if (sq !== 4'b0) begin n_fail++; $display("FAIL reset_sq: got %b expected 0000", sq); end
      n_checks++; if (wr_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b expected 0", wr_ack); end
      n_checks++; if (wr_ack3 !== 1'b0) begin n_fail++; $display("FAIL reset_ack3: got %b expected 0", wr_ack3); end
      for (int i = 0; i < 4; i++) begin
         n_checks++; if (main_per(i) !== DEF) begin n_fail++; $display("FAIL reset_per ch%0d: got %0d expected %0d", i, main_per(i), DEF); end
         n_checks++; if (main_cnt(i) !== 25'd0) begin n_fail++; $display("FAIL reset_cnt ch%0d: got %0d expected 0", i, main_cnt(i)); end
      end
      p = period_for_hz(40);
      n_checks++; if (p !== 25'd1250000) begin n_fail++; $display("FAIL period_for_hz_40: got %0d expected 1250000", p); end
      p = period_for_hz(10000000);
      n_checks++; if (p !== 25'd5) begin n_fail++; $display("FAIL period_for_hz_10M: got %0d expected 5", p); end
   endtask

   task automatic test_basic_period();
      logic et, es;
      do_reset();
      wr_en = 1'b1; wr_ch = 2'd0; wr_period = 25'd5;
      cyc();
      n_checks++; if (wr_ack !== 1'b1) begin n_fail++; $display("FAIL basic_ack: got %b expected 1", wr_ack); end
      wr_en = 1'b0; en = 4'b0001;
      for (int k = 1; k <= 15; k++) begin
         cyc();
         et = (k % 5 == 0);
         es = ((k / 5) % 2 == 1);
         n_checks++; if (tick[0] !== et) begin n_fail++; $display("FAIL basic_tick k=%0d: got %b expected %b", k, tick[0], et); end
         n_checks++; if (sq[0] !== es) begin n_fail++; $display("FAIL basic_sq k=%0d: got %b expected %b", k, sq[0], es); end
         n_checks++; if ({tick[3:1], sq[3:1]} !== 6'b0) begin n_fail++; $display("FAIL basic_idle k=%0d: got %b expected 000000", k, {tick[3:1], sq[3:1]}); end
         if (k == 1) begin
            n_checks++; if (wr_ack !== 1'b0) begin n_fail++; $display("FAIL basic_ack_width: got %b expected 0", wr_ack); end
         end
      end
   endtask

   task automatic test_write_midcount();
      do_reset();
      wr_en = 1'b1; wr_ch = 2'd2; wr_period = 25'd10; en = 4'b0100;
      cyc();
      wr_en = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         cyc();
         n_checks++; if (tick[2] !== 1'b0) begin n_fail++; $display("FAIL mid_pre_tick k=%0d: got %b expected 0", k, tick[2]); end
      end
      n_checks++; if (main_cnt(2) !== 25'd7) begin n_fail++; $display("FAIL mid_cnt7: got %0d expected 7", main_cnt(2)); end
      wr_en = 1'b1; wr_ch = 2'd2; wr_period = 25'd3;
      cyc();
      wr_en = 1'b0;
      n_checks++; if (wr_ack !== 1'b1) begin n_fail++; $display("FAIL mid_ack: got %b expected 1", wr_ack); end
      n_checks++; if (main_cnt(2) !== 25'd0) begin n_fail++; $display("FAIL mid_cnt_restart: got %0d expected 0", main_cnt(2)); end
      n_checks++; if (main_per(2) !== 25'd3) begin n_fail++; $display("FAIL mid_per: got %0d expected 3", main_per(2)); end
      for (int k = 1; k <= 3; k++) begin
         cyc();
         n_checks++; if (tick[2] !== (k == 3)) begin n_fail++; $display("FAIL mid_tick k=%0d: got %b expected %b", k, tick[2], (k == 3)); end
         if (k == 1) begin
            n_checks++; if (wr_ack !== 1'b0) begin n_fail++; $display("FAIL mid_ack_width: got %b expected 0", wr_ack); end
         end
      end
      n_checks++; if (sq[2] !== 1'b1) begin n_fail++; $display("FAIL mid_sq: got %b expected 1", sq[2]); end
      // Two more edges reach cnt = 2 = per-1; a write on the terminal edge drops that tick.
      cyc();
      cyc();
      wr_en = 1'b1; wr_ch = 2'd2; wr_period = 25'd3;
      cyc();
      wr_en = 1'b0;
      n_checks++; if (tick[2] !== 1'b0) begin n_fail++; $display("FAIL mid_lost_tick: got %b expected 0", tick[2]); end
      n_checks++; if (sq[2] !== 1'b1) begin n_fail++; $display("FAIL mid_lost_sq: got %b expected 1", sq[2]); end
   endtask

   task automatic test_sync_back_to_back();
      do_reset();
      wr_en = 1'b1; wr_ch = 2'd0; wr_period = 25'd4;
      cyc();
      n_checks++; if (wr_ack !== 1'b1) begin n_fail++; $display("FAIL b2b_ack0: got %b expected 1", wr_ack); end
      wr_ch = 2'd1; wr_period = 25'd6;
      cyc();
      n_checks++; if (wr_ack !== 1'b1) begin n_fail++; $display("FAIL b2b_ack1: got %b expected 1", wr_ack); end
      wr_en = 1'b0;
      cyc();
      n_checks++; if (wr_ack !== 1'b0) begin n_fail++; $display("FAIL b2b_ack_end: got %b expected 0", wr_ack); end
      n_checks++; if ({main_per(1), main_per(0)} !== {25'd6, 25'd4}) begin n_fail++; $display("FAIL b2b_per: got %0d/%0d expected 6/4", main_per(1), main_per(0)); end
      en = 4'b0011;
      repeat (7) cyc();
      n_checks++; if (sq[1:0] !== 2'b11) begin n_fail++; $display("FAIL sync_pre_sq: got %b expected 11", sq[1:0]); end
      // ch0 is at its terminal count here; sync suppresses that tick.
      sync = 1'b1;
      cyc();
      sync = 1'b0;
      n_checks++; if (sq[1:0] !== 2'b00) begin n_fail++; $display("FAIL sync_sq: got %b expected 00", sq[1:0]); end
      n_checks++; if (tick[1:0] !== 2'b00) begin n_fail++; $display("FAIL sync_tick: got %b expected 00", tick[1:0]); end
      for (int k = 1; k <= 6; k++) begin
         cyc();
         n_checks++; if (tick[0] !== (k == 4)) begin n_fail++; $display("FAIL sync_tick0 k=%0d: got %b expected %b", k, tick[0], (k == 4)); end
         n_checks++; if (tick[1] !== (k == 6)) begin n_fail++; $display("FAIL sync_tick1 k=%0d: got %b expected %b", k, tick[1], (k == 6)); end
      end
      n_checks++; if (sq[1:0] !== 2'b11) begin n_fail++; $display("FAIL sync_post_sq: got %b expected 11", sq[1:0]); end
      sync = 1'b1; wr_en = 1'b1; wr_ch = 2'd0; wr_period = 25'd2;
      cyc();
      sync = 1'b0; wr_en = 1'b0;
      n_checks++; if (wr_ack !== 1'b1) begin n_fail++; $display("FAIL sync_wr_ack: got %b expected 1", wr_ack); end
      n_checks++; if (main_per(0) !== 25'd2) begin n_fail++; $display("FAIL sync_wr_per: got %0d expected 2", main_per(0)); end
      n_checks++; if (sq[1:0] !== 2'b00) begin n_fail++; $display("FAIL sync_wr_sq: got %b expected 00", sq[1:0]); end
      for (int k = 1; k <= 2; k++) begin
         cyc();
         n_checks++; if (tick[0] !== (k == 2)) begin n_fail++; $display("FAIL sync_wr_tick k=%0d: got %b expected %b", k, tick[0], (k == 2)); end
      end
   endtask

   task automatic test_per_one_zero();
      do_reset();
      wr_en = 1'b1; wr_ch = 2'd1; wr_period = 25'd1;
      cyc();
      wr_en = 1'b0; en = 4'b0010;
      for (int k = 1; k <= 5; k++) begin
         cyc();
         n_checks++; if (tick[1] !== 1'b1) begin n_fail++; $display("FAIL per1_tick k=%0d: got %b expected 1", k, tick[1]); end
         n_checks++; if (sq[1] !== (k % 2 == 1)) begin n_fail++; $display("FAIL per1_sq k=%0d: got %b expected %b", k, sq[1], (k % 2 == 1)); end
      end
      wr_en = 1'b1; wr_ch = 2'd1; wr_period = 25'd0;
      cyc();
      wr_en = 1'b0;
      n_checks++; if (wr_ack !== 1'b1) begin n_fail++; $display("FAIL per0_ack: got %b expected 1", wr_ack); end
      for (int k = 0; k <= 5; k++) begin
         if (k > 0) cyc();
         n_checks++; if (tick[1] !== 1'b0) begin n_fail++; $display("FAIL per0_tick k=%0d: got %b expected 0", k, tick[1]); end
         n_checks++; if (sq[1] !== 1'b1) begin n_fail++; $display("FAIL per0_sq k=%0d: got %b expected 1", k, sq[1]); end
      end
   endtask

   task automatic test_enable_pause();
      do_reset();
      wr_en = 1'b1; wr_ch = 2'd3; wr_period = 25'd8;
      cyc();
      wr_en = 1'b0; en = 4'b1000;
      cyc();
      cyc();
      n_checks++; if (main_cnt(3) !== 25'd2) begin n_fail++; $display("FAIL pause_cnt_pre: got %0d expected 2", main_cnt(3)); end
      en = 4'b0000;
      for (int k = 1; k <= 20; k++) begin
         cyc();
         n_checks++; if (tick[3] !== 1'b0) begin n_fail++; $display("FAIL pause_tick k=%0d: got %b expected 0", k, tick[3]); end
      end
      n_checks++; if (main_cnt(3) !== 25'd2) begin n_fail++; $display("FAIL pause_cnt_held: got %0d expected 2", main_cnt(3)); end
      en = 4'b1000;
      for (int k = 1; k <= 6; k++) begin
         cyc();
         n_checks++; if (tick[3] !== (k == 6)) begin n_fail++; $display("FAIL resume_tick k=%0d: got %b expected %b", k, tick[3], (k == 6)); end
      end
      n_checks++; if (sq[3] !== 1'b1) begin n_fail++; $display("FAIL resume_sq: got %b expected 1", sq[3]); end
   endtask

   task automatic test_bad_channel();
      do_reset();
      wr_en = 1'b1; wr_ch = 2'd3; wr_period = 25'd2;
      cyc();
      wr_en = 1'b0;
      n_checks++; if (wr_ack3 !== 1'b0) begin n_fail++; $display("FAIL bad_ch_ack: got %b expected 0", wr_ack3); end
      n_checks++; if (wr_ack !== 1'b1) begin n_fail++; $display("FAIL good_ch3_ack: got %b expected 1", wr_ack); end
      n_checks++; if (main_per(3) !== 25'd2) begin n_fail++; $display("FAIL good_ch3_per: got %0d expected 2", main_per(3)); end
      for (int i = 0; i < 3; i++) begin
         n_checks++; if (d3_per(i) !== DEF) begin n_fail++; $display("FAIL bad_ch_per ch%0d: got %0d expected %0d", i, d3_per(i), DEF); end
      end
      wr_en = 1'b1; wr_ch = 2'd2; wr_period = 25'd7;
      cyc();
      wr_en = 1'b0;
      n_checks++; if (wr_ack3 !== 1'b1) begin n_fail++; $display("FAIL d3_ch2_ack: got %b expected 1", wr_ack3); end
      n_checks++; if (d3_per(2) !== 25'd7) begin n_fail++; $display("FAIL d3_ch2_per: got %0d expected 7", d3_per(2)); end
   endtask

   task automatic test_reset_midcount();
      do_reset();
      wr_en = 1'b1; wr_ch = 2'd0; wr_period = 25'd1;
      cyc();
      en = 4'b0001; wr_ch = 2'd2; wr_period = 25'd9;
      cyc();
      wr_en = 1'b0;
      n_checks++; if ({wr_ack, tick[0], sq[0]} !== 3'b111) begin n_fail++; $display("FAIL rst_pre: got %b expected 111", {wr_ack, tick[0], sq[0]}); end
      #2;
      resetn = 1'b0;
      #1;
      n_checks++; if ({wr_ack, tick, sq} !== 9'b0) begin n_fail++; $display("FAIL rst_async_out: got %b expected 0", {wr_ack, tick, sq}); end
      for (int i = 0; i < 4; i++) begin
         n_checks++; if (main_per(i) !== DEF) begin n_fail++; $display("FAIL rst_async_per ch%0d: got %0d expected %0d", i, main_per(i), DEF); end
         n_checks++; if (main_cnt(i) !== 25'd0) begin n_fail++; $display("FAIL rst_async_cnt ch%0d: got %0d expected 0", i, main_cnt(i)); end
      end
      en = 4'b0000;
      cyc();
      resetn = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         cyc();
         n_checks++; if ({wr_ack, tick, sq} !== 9'b0) begin n_fail++; $display("FAIL rst_after k=%0d: got %b expected 0", k, {wr_ack, tick, sq}); end
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic_period();
      test_write_midcount();
      test_sync_back_to_back();
      test_per_one_zero();
      test_enable_pause();
      test_bad_channel();
      test_reset_midcount();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/instr_tick_gen.md
# instr_tick_gen

Parametrised multi-channel tick generator for the audio synthesizer: each of NUM_CH channels divides CLOCK_50 by an independently programmable period. Each channel emits a one-cycle tick pulse and a 50%-duty square wave. It replaces the fixed single-rate instrument divider and feeds note sequencers and envelope steppers, one channel per instrument voice. Periods are runtime-writable with a write acknowledge, and all channels can be phase-aligned by a global sync.

## Interface
- NUM_CH, 4, number of independent channels
- CNT_W, 25, counter and period width in bits
- DEFAULT_PERIOD, 1250000, period loaded into every channel at reset, in CLOCK_50 cycles
- CH_W, $clog2(NUM_CH) (min 1), width of the channel select
- CLOCK_50  in  1  system clock; all logic is on its rising edge
- resetn  in  1  asynchronous, active-low reset
- en  in  NUM_CH  per-channel run enable
- sync  in  1  global phase restart of all channels
- wr_en  in  1  period write strobe, single cycle
- wr_ch  in  CH_W  channel to write
- wr_period  in  CNT_W  new period, in cycles
- wr_ack  out  1  one-cycle pulse confirming an accepted write
- tick  out  NUM_CH  one-cycle pulse per elapsed period
- sq  out  NUM_CH  square wave that toggles on each tick

## Operation
- Per-channel state: per[i] (CNT_W bits), cnt[i] (CNT_W bits), tick[i], sq[i].
- Reset: per = DEFAULT_PERIOD, cnt = 0, tick = 0, sq = 0, wr_ack = 0, all asynchronously.
- Priority per channel, highest first: sync, write to this channel, run, hold.
- sync = 1: every cnt = 0, every sq = 0, every tick = 0. A simultaneous write still updates per, and wr_ack still pulses.
- Write (wr_en = 1 and wr_ch < NUM_CH):
  - per[wr_ch] = wr_period; cnt[wr_ch] = 0; tick[wr_ch] = 0; sq unchanged.
  - wr_ack = 1 on the next cycle.
  - A write takes priority over a coincident terminal count, so that tick is lost.
- wr_ch >= NUM_CH: the write is ignored and wr_ack stays 0.
- Run (en[i] = 1 and per[i] != 0):
  - If cnt[i] == per[i]-1: cnt = 0, tick = 1, sq toggles.
  - Otherwise: cnt = cnt + 1, tick = 0.
- Hold (en[i] = 0, or per[i] == 0): cnt and sq frozen, tick = 0. De-asserting en pauses a channel; it does not reset the phase.
- per = 1: tick is held high continuously and sq toggles every cycle.
- Counter compare uses per-1 in CNT_W-bit unsigned arithmetic. per = 0 is excluded before the compare, so there is no wrap-around.

## Timing
- All outputs are registered. There are no combinational paths from inputs to outputs.
- From cnt = 0 with en held high, the first tick is asserted P rising edges later, then every P cycles after that. The sq period is 2P.
- Write, sync, or enable-change effects are visible on the edge that samples them.
- wr_ack is high exactly one cycle, the cycle after the accepted wr_en.
- Back-to-back writes on consecutive cycles are all accepted, and each produces its own wr_ack pulse.
- resetn asserted mid-count clears all state immediately. After release, channels restart from cnt = 0 with DEFAULT_PERIOD.

## Structure
- Package instr_tick_pkg holds:
  - the CNT_W default and DEFAULT_PERIOD;
  - the constant CLK_HZ = 50000000;
  - a function period_for_hz(hz) = CLK_HZ/hz, used by the sequencer when programming channels.
- Sub-module tick_channel holds one channel's counter, period register, tick and sq. It takes the inputs en, sync, ld, ld_val.
- instr_tick_gen instantiates NUM_CH tick_channel copies with a generate loop. It also contains the write-address decode and the wr_ack register.

## Test plan
- Reset then enable channel 0 with per = 5: tick[0] pulses on cycles 5, 10, 15 after enable; sq[0] reads 1, 0, 1 after each pulse; other channels stay idle.
- Write ch 2 period 3 while ch 2 is mid-count at cnt = 7 of 10: cnt restarts, wr_ack is high for one cycle, and the next tick[2] comes 3 cycles after the write.
- Channels 0 and 1 at periods 4 and 6, sync pulsed: both sq go to 0; tick[0] then fires at +4 and tick[1] at +6, aligned from the sync edge.
- per = 1 on ch 1: tick[1] is held high and sq[1] toggles every cycle. per = 0 on ch 1: tick[1] = 0 and sq[1] is frozen.
- De-assert en[3] at cnt = 2 of 8 for 20 cycles, then re-enable: tick[3] fires 6 cycles after re-enable.
- wr_ch = NUM_CH: no period changes and wr_ack = 0. resetn pulsed mid-count: all outputs return to 0 and per returns to 1250000 on every channel.
